mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 144 ++++++++++++++
 tb/tb_mult_div_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit for MIPS mult/multu/div/divu into HI/LO.
// Operands are reduced to magnitudes on accept. The core iterates unsigned: shift-add for
// multiply and restoring shift-subtract for divide. A single FIX cycle restores the signs.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic                 is_div_q;
    logic                 neg_lo_q;      // negate product / quotient in FIX
    logic                 neg_hi_q;      // negate remainder in FIX (dividend sign)
    logic                 bzero_q;
    logic [WIDTH-1:0]     opnd_q;        // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0]   acc_q;         // product accumulator; low half is dividend/quotient
    logic [WIDTH:0]       rem_q;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 dbz_q, busy_q, done_q;

    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_mag, quo_fix, rem_mag, rem_fix;
    logic                 unused_rem_msb;

    // Operand sign extraction; unsigned ops take raw values.
    always_comb begin
        sign_a = ~op[0] & a[WIDTH-1];
        sign_b = ~op[0] & b[WIDTH-1];
        abs_a  = sign_a ? -a : a;
        abs_b  = sign_b ? -b : b;
    end

    // One iteration step for each algorithm, plus the sign-corrected results used in FIX.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH + 1){1'b0}});
        div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        // A partial remainder never exceeds 2*divisor-1, so the MSB of the difference
        // is a clean borrow flag.
        div_ge    = ~div_diff[WIDTH];
        prod_fix  = neg_lo_q ? -acc_q : acc_q;
        quo_mag   = acc_q[WIDTH-1:0];
        quo_fix   = neg_lo_q ? -quo_mag : quo_mag;
        rem_mag   = rem_q[WIDTH-1:0];
        rem_fix   = neg_hi_q ? -rem_mag : rem_mag;
    end

    // After a restoring step the stored remainder is always below the divisor.
    assign unused_rem_msb = rem_q[WIDTH];

    // Control FSM and datapath registers; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            bzero_q  <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        is_div_q <= op[1];
                        neg_lo_q <= sign_a ^ sign_b;
                        neg_hi_q <= op[1] ? sign_a : (sign_a ^ sign_b);
                        bzero_q  <= (b == '0);
                        opnd_q   <= op[1] ? abs_b : abs_a;
                        acc_q    <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                        rem_q    <= '0;
                        cnt_q    <= CntW'(WIDTH);
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    if (is_div_q) begin
                        acc_q[WIDTH-1:0] <= {acc_q[WIDTH-2:0], div_ge};
                        rem_q            <= div_ge ? div_diff : div_shift;
                    end else begin
                        acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    if (is_div_q) begin
                        // Divide by zero: the remainder already equals the raw dividend.
                        hi_q <= rem_fix;
                        lo_q <= bzero_q ? {WIDTH{1'b1}} : quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    dbz_q   <= is_div_q & bzero_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/div_by_zero are queued when an
// operation is issued and compared when done pulses.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Reference arithmetic built on wide signed/unsigned operators.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.dbz = 1'b0;
        case (o)
            2'd0: begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'd1: begin p = {32'd0, x} * {32'd0, y}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (y == 0) begin
                    e.hi = x; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
                end else if (o == 2'd2) begin
                    q = sx / sy; r = sx % sy;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end else begin
                    e.lo = x / y; e.hi = x % y;
                end
            end
        endcase
        return e;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_done", done, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("hi", hi, mon_e.hi);
                check_eq("lo", lo, mon_e.lo);
                check_eq("div_by_zero", div_by_zero, mon_e.dbz);
            end
        end
    end

    // Called at a negedge; returns #1 after the accept edge with inputs scrambled.
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                            input exp_t e);
        op = o; a = x; b = y; start = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    // Waits for done; cyc counts edges from the accept edge (inclusive) to the done edge.
    task automatic wait_done(output int cyc, output int bcnt, output bit held);
        logic [31:0] h0, l0;
        bit          seen;
        h0 = hi; l0 = lo;
        cyc = 1; bcnt = 0; held = 1'b1; seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (busy && (hi !== h0 || lo !== l0)) held = 1'b0;
            if (done) seen = 1'b1;
            else begin
                @(posedge clk);
                cyc++;
            end
        end
        check_eq("done_seen", {63'd0, seen}, 1);
    endtask

    initial begin
        int          cyc, bcnt;
        bit          held;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_hi", hi, 0);
        check_eq("rst_lo", lo, 0);
        check_eq("rst_dbz", div_by_zero, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // multu max*max: latency and busy width
        start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
        wait_done(cyc, bcnt, held);
        check_eq("multu_latency", cyc, 34);
        check_eq("multu_busy_cycles", bcnt, 33);

        // back-to-back accept in DONE: second done 34 cycles after the first
        start_op(2'd0, 32'hFFFF_FFFD, 32'd5, '{32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0});
        wait_done(cyc, bcnt, held);
        check_eq("b2b_latency", cyc, 34);
        check_eq("hilo_hold_in_run", {63'd0, held}, 1);

        @(negedge clk);
        start_op(2'd0, 32'h8000_0000, 32'h8000_0000, '{32'h4000_0000, 32'h0000_0000, 1'b0});
        wait_done(cyc, bcnt, held);
        check_eq("lo_zero_flag", {63'd0, (lo == 32'd0)}, 1);

        @(negedge clk);
        start_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, '{32'h0000_0000, 32'h8000_0000, 1'b0});
        wait_done(cyc, bcnt, held);

        @(negedge clk);
        start_op(2'd3, 32'd100, 32'd0, '{32'h0000_0064, 32'hFFFF_FFFF, 1'b1});
        wait_done(cyc, bcnt, held);
        check_eq("divu0_latency", cyc, 34);

        // start pulsed mid-run with new operands must be ignored
        @(negedge clk);
        start_op(2'd2, 32'hFFFF_FFF9, 32'd2, '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
        repeat (9) @(posedge clk);
        @(negedge clk);
        op = 2'd3; a = 32'd256; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(cyc, bcnt, held);

        // reset mid-run abandons the operation
        @(negedge clk);
        start_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, model(2'd1, 32'h1234_5678, 32'h9ABC_DEF0));
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_hi", hi, 0);
        check_eq("abort_lo", lo, 0);
        void'(sb_q.pop_front());
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("abort_no_done_hi", hi, 0);
        start_op(2'd0, 32'h8000_0000, 32'h8000_0000, '{32'h4000_0000, 32'h0000_0000, 1'b0});
        wait_done(cyc, bcnt, held);
        check_eq("post_abort_latency", cyc, 34);

        // random operations against the reference model
        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : (i % 2 == 1) ? 32'($urandom_range(1, 40)) : $urandom;
            if (i % 3 != 0) @(negedge clk);
            start_op(ro, ra, rb, model(ro, ra, rb));
            wait_done(cyc, bcnt, held);
            check_eq("rand_latency", cyc, 34);
        end

        @(negedge clk);
        check_eq("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
